// File: rtl/text_console_writer_pkg.sv
// Shared console/game types, text geometry, control codes and cell addressing.
package text_console_writer_pkg;

    typedef enum logic [1:0] {MODE_ATTRACT, MODE_PLAY, MODE_OVER} game_mode_t;

    typedef enum logic [0:0] {CONS_IDLE = 1'b0, CONS_CLEAR = 1'b1} console_state_t;

    localparam int COLS   = 28;
    localparam int ROWS   = 36;
    localparam int CELLS  = COLS * ROWS;
    localparam int COL_W  = $clog2(COLS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int ADDR_W = $clog2(CELLS);

    localparam logic [7:0] ASCII_SPACE  = 8'h20;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_FF     = 8'h0C;
    localparam logic [7:0] ASCII_BS     = 8'h08;
    localparam logic [7:0] ASCII_CURSOR = 8'h5F;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return ADDR_W'(int'(row) * COLS + int'(col));
    endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// Producer handshake, cursor status and renderer read port of the text console.
interface text_console_writer_if;
    import text_console_writer_pkg::*;

    logic             in_valid;
    logic [7:0]       in_char;
    logic             in_ready;
    logic             busy;
    logic [COL_W-1:0] cursor_col;
    logic [ROW_W-1:0] cursor_row;
    logic [7:0]       sx;
    logic [8:0]       sy;
    logic [7:0]       ascii_char;

    modport master (output in_valid, in_char, sx, sy,
                    input  in_ready, busy, cursor_col, cursor_row, ascii_char);
    modport slave  (input  in_valid, in_char, sx, sy,
                    output in_ready, busy, cursor_col, cursor_row, ascii_char);

endinterface

// File: rtl/text_console_writer_char_ram.sv
// Simple dual-port glyph RAM: one write port, one read-first read port, 1-cycle read.
module char_ram #(
    parameter int DEPTH = 1008,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_dat
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_dat;
        rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/text_console_writer.sv
// Cursor-driven ASCII writer into the text buffer; read port returns a cell 1 cycle after sx/sy.
// in_ready drops while the buffer clears; TEXT_CONSOLE_CURSOR_EN overlays '_' at the cursor.
module text_console_writer
    import text_console_writer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    text_console_writer_if.slave bus
);

    localparam logic [0:0]        ST_IDLE  = 1'(CONS_IDLE);
    localparam logic [0:0]        ST_CLEAR = 1'(CONS_CLEAR);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CELLS - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ROW_W-1:0]  row_next;
    logic              idle, fire, printable;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_dat;

    assign idle      = (state == ST_IDLE);
    assign fire      = bus.in_valid && idle;
    assign printable = (bus.in_char >= ASCII_SPACE) && (bus.in_char <= 8'h7E);
    assign row_next  = (row == ROW_LAST) ? '0 : row + 1'b1;

    assign bus.in_ready   = idle;
    assign bus.busy       = !idle;
    assign bus.cursor_col = col;
    assign bus.cursor_row = row;

    // A character arriving alongside rst must not reach the buffer.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clr_cnt;
        wr_dat  = ASCII_SPACE;
        if (!rst) begin
            if (!idle) begin
                wr_en = 1'b1;
            end else if (fire && printable) begin
                wr_en   = 1'b1;
                wr_addr = cell_addr(row, col);
                wr_dat  = bus.in_char;
            end else if (fire && bus.in_char == ASCII_BS && col != '0) begin
                wr_en   = 1'b1;
                wr_addr = cell_addr(row, col - 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            col     <= '0;
            row     <= '0;
        end else if (!idle) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == CLR_LAST)
                state <= ST_IDLE;
        end else if (fire) begin
            case (bus.in_char)
                ASCII_LF: begin
                    col <= '0;
                    row <= row_next;
                end
                ASCII_CR: col <= '0;
                ASCII_BS: if (col != '0) col <= col - 1'b1;
                ASCII_FF: begin
                    state   <= ST_CLEAR;
                    clr_cnt <= '0;
                    col     <= '0;
                    row     <= '0;
                end
                default: begin
                    if (printable) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= row_next;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    logic [COL_W-1:0]  col_r;
    logic [ROW_W-1:0]  row_r;
    logic              rd_oob;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_dat;
    logic              force_space;

    assign col_r   = COL_W'(bus.sx >> 3);
    assign row_r   = ROW_W'(bus.sy >> 3);
    assign rd_oob  = (col_r > COL_LAST) || (row_r > ROW_LAST);
    assign rd_addr = rd_oob ? '0 : cell_addr(row_r, col_r);

    char_ram #(.DEPTH(CELLS), .AW(ADDR_W)) u_char_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_dat  (wr_dat),
        .rd_addr (rd_addr),
        .rd_dat  (rd_dat)
    );

    // The RAM output has no reset, so a registered flag masks it to a space.
    always_ff @(posedge clk) begin
        if (rst)
            force_space <= 1'b1;
        else
            force_space <= rd_oob;
    end

`ifdef TEXT_CONSOLE_CURSOR_EN
    logic cursor_hit;

    always_ff @(posedge clk) begin
        if (rst)
            cursor_hit <= 1'b0;
        else
            cursor_hit <= idle && (col_r == col) && (row_r == row);
    end

    assign bus.ascii_char = force_space ? ASCII_SPACE :
                            cursor_hit  ? ASCII_CURSOR : rd_dat;
`else
    assign bus.ascii_char = force_space ? ASCII_SPACE : rd_dat;
`endif

endmodule

// File: tb/tb_text_console_writer.sv
// Randomized bench for text_console_writer against a screen/cursor reference model.
module tb_text_console_writer;
    import text_console_writer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    text_console_writer_if tif();

    text_console_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (tif)
    );

    byte unsigned scr [ROWS][COLS];
    int           cc, cr;

    function automatic void model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = 8'h20;
        cc = 0;
        cr = 0;
    endfunction

    function automatic void model_apply(input logic [7:0] ch);
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            scr[cr][cc] = ch;
            cc = cc + 1;
            if (cc == COLS) begin
                cc = 0;
                cr = (cr + 1) % ROWS;
            end
        end else if (ch == 8'h0A) begin
            cc = 0;
            cr = (cr + 1) % ROWS;
        end else if (ch == 8'h0D) begin
            cc = 0;
        end else if (ch == 8'h08) begin
            if (cc > 0) begin
                cc = cc - 1;
                scr[cr][cc] = 8'h20;
            end
        end else if (ch == 8'h0C) begin
            model_clear();
        end
    endfunction

    function automatic logic [7:0] model_read(input int x, input int y);
        int col, row;
        col = x / 8;
        row = y / 8;
        if (col >= COLS || row >= ROWS)
            return 8'h20;
`ifdef TEXT_CONSOLE_CURSOR_EN
        if (col == cc && row == cr)
            return 8'h5F;
`endif
        return scr[row][col];
    endfunction

    // Offers one character and holds it until accepted; returns on the negedge after the transfer.
    task automatic send_char(input logic [7:0] ch);
        int n;
        tif.in_valid = 1'b1;
        tif.in_char  = ch;
        n = 0;
        while (!tif.in_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) begin
            vectors++;
            miscompares++;
            $display("FAIL send_wait: in_ready still %b after %0d cycles, required 1", tif.in_ready, n);
        end
        @(negedge clk);
        tif.in_valid = 1'b0;
        model_apply(ch);
    endtask

    task automatic read_cell(input int x, input int y, output logic [7:0] got);
        tif.sx = 8'(x);
        tif.sy = 9'(y);
        @(negedge clk);
        got = tif.ascii_char;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!tif.in_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        tif.in_valid = 1'b0;
        tif.in_char  = 8'h00;
        tif.sx = 8'd0;
        tif.sy = 9'd0;
        repeat (2) @(negedge clk);
        vectors++;
        if (tif.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b required 0", tif.in_ready);
        end
        vectors++;
        if (tif.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_busy: got %b required 1", tif.busy);
        end
        vectors++;
        if (tif.cursor_col !== '0 || tif.cursor_row !== '0) begin
            miscompares++;
            $display("FAIL reset_cursor: got (%0d,%0d) required (0,0)", tif.cursor_col, tif.cursor_row);
        end
        vectors++;
        if (tif.ascii_char !== 8'h20) begin
            miscompares++;
            $display("FAIL reset_ascii: got %h required 20", tif.ascii_char);
        end
        rst = 1'b0;
        model_clear();
        wait_ready(n);
        vectors++;
        if (n != CELLS) begin
            miscompares++;
            $display("FAIL reset_clear_len: in_ready low %0d cycles, required %0d", n, CELLS);
        end
    endtask

    task automatic test_sweep(input string name);
        logic [7:0] got, exp;
        int         x, y, bad;
        bad = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                x = c * 8 + int'($urandom_range(7, 0));
                y = r * 8 + int'($urandom_range(7, 0));
                exp = model_read(x, y);
                read_cell(x, y, got);
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    bad++;
                    if (bad <= 8)
                        $display("FAIL sweep_%s cell(%0d,%0d): got %h required %h", name, c, r, got, exp);
                end
            end
        end
    endtask

    task automatic test_hi();
        logic [7:0] got;
        send_char(8'h48);
        send_char(8'h49);
        read_cell(0, 0, got);
        vectors++;
        if (got !== 8'h48) begin
            miscompares++;
            $display("FAIL hi_cell0: got %h required 48", got);
        end
        read_cell(8, 0, got);
        vectors++;
        if (got !== 8'h49) begin
            miscompares++;
            $display("FAIL hi_cell1: got %h required 49", got);
        end
        vectors++;
        if (tif.cursor_col !== 5'd2 || tif.cursor_row !== 6'd0) begin
            miscompares++;
            $display("FAIL hi_cursor: got (%0d,%0d) required (2,0)", tif.cursor_col, tif.cursor_row);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        int         t0;
        send_char(8'h0C);
        send_char(8'h41);
        t0 = cyc;
        repeat (COLS - 1) send_char(8'h41);
        vectors++;
        if (cyc - t0 != COLS - 1) begin
            miscompares++;
            $display("FAIL b2b_rate: %0d cycles for %0d chars, required %0d", cyc - t0, COLS - 1, COLS - 1);
        end
        send_char(8'h42);
        for (int c = 0; c < COLS; c++) begin
            read_cell(c * 8, 4, got);
            vectors++;
            if (got !== 8'h41) begin
                miscompares++;
                $display("FAIL rowfill_col%0d: got %h required 41", c, got);
            end
        end
        read_cell(3, 8, got);
        vectors++;
        if (got !== 8'h42) begin
            miscompares++;
            $display("FAIL rowfill_wrapcell: got %h required 42", got);
        end
        vectors++;
        if (tif.cursor_col !== 5'd1 || tif.cursor_row !== 6'd1) begin
            miscompares++;
            $display("FAIL rowfill_cursor: got (%0d,%0d) required (1,1)", tif.cursor_col, tif.cursor_row);
        end
    endtask

    task automatic test_controls();
        logic [7:0] got, exp;
        send_char(8'h0C);
        repeat (ROWS - 1) send_char(8'h0A);
        vectors++;
        if (tif.cursor_col !== 5'd0 || tif.cursor_row !== 6'(ROWS - 1)) begin
            miscompares++;
            $display("FAIL lf_last_row: got (%0d,%0d) required (0,%0d)", tif.cursor_col, tif.cursor_row, ROWS - 1);
        end
        send_char(8'h0A);
        vectors++;
        if (tif.cursor_row !== 6'd0) begin
            miscompares++;
            $display("FAIL lf_wrap: got row %0d required 0", tif.cursor_row);
        end
        send_char(8'h41);
        send_char(8'h42);
        send_char(8'h08);
        vectors++;
        if (tif.cursor_col !== 5'd1 || tif.cursor_row !== 6'd0) begin
            miscompares++;
            $display("FAIL bs_cursor: got (%0d,%0d) required (1,0)", tif.cursor_col, tif.cursor_row);
        end
        send_char(8'h0D);
        vectors++;
        if (tif.cursor_col !== 5'd0) begin
            miscompares++;
            $display("FAIL cr_cursor: got col %0d required 0", tif.cursor_col);
        end
        read_cell(8, 0, got);
        vectors++;
        if (got !== 8'h20) begin
            miscompares++;
            $display("FAIL bs_erased: got %h required 20", got);
        end
        send_char(8'h08);
        vectors++;
        if (tif.cursor_col !== 5'd0 || tif.cursor_row !== 6'd0) begin
            miscompares++;
            $display("FAIL bs_col0_cursor: got (%0d,%0d) required (0,0)", tif.cursor_col, tif.cursor_row);
        end
        exp = model_read(0, 0);
        read_cell(0, 0, got);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL bs_col0_cell: got %h required %h", got, exp);
        end
    endtask

    task automatic test_read_first();
        logic [7:0] got, exp_old, exp_new;
        tif.sx = 8'd0;
        tif.sy = 9'd0;
        exp_old = model_read(0, 0);
        send_char(8'h5A);
        got = tif.ascii_char;
        vectors++;
        if (got !== exp_old) begin
            miscompares++;
            $display("FAIL read_first_old: got %h required %h", got, exp_old);
        end
        exp_new = model_read(0, 0);
        @(negedge clk);
        got = tif.ascii_char;
        vectors++;
        if (got !== exp_new) begin
            miscompares++;
            $display("FAIL read_first_new: got %h required %h", got, exp_new);
        end
    endtask

    task automatic test_clear();
        logic [7:0] got, exp;
        int         n;
        send_char(8'h0A);
        send_char(8'h20);
        send_char(8'h58);
        send_char(8'h0C);
        vectors++;
        if (tif.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ff_ready_drop: got %b required 0", tif.in_ready);
        end
        n = 0;
        while (tif.busy === 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n != CELLS) begin
            miscompares++;
            $display("FAIL ff_busy_len: busy %0d cycles, required %0d", n, CELLS);
        end
        exp = model_read(8, 8);
        read_cell(8, 8, got);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL ff_x_cleared: got %h required %h", got, exp);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        send_char(8'h0C);
        repeat (500) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        wait_ready(n);
        vectors++;
        if (n != CELLS) begin
            miscompares++;
            $display("FAIL midclear_restart: in_ready low %0d cycles, required %0d", n, CELLS);
        end
    endtask

    task automatic test_reset_mid_stream();
        int n;
        send_char(8'h4B);
        send_char(8'h4C);
        rst = 1'b1;
        tif.in_valid = 1'b1;
        tif.in_char  = 8'h51;
        @(negedge clk);
        rst = 1'b0;
        tif.in_valid = 1'b0;
        model_clear();
        wait_ready(n);
        vectors++;
        if (n != CELLS) begin
            miscompares++;
            $display("FAIL midstream_restart: in_ready low %0d cycles, required %0d", n, CELLS);
        end
        vectors++;
        if (tif.cursor_col !== 5'd0 || tif.cursor_row !== 6'd0) begin
            miscompares++;
            $display("FAIL midstream_cursor: got (%0d,%0d) required (0,0)", tif.cursor_col, tif.cursor_row);
        end
    endtask

    task automatic test_random();
        logic [7:0] junk [11];
        logic [7:0] ch, got, exp;
        int         sel, x, y, bad;
        junk = '{8'h00, 8'h01, 8'h07, 8'h09, 8'h0B, 8'h0E, 8'h1F, 8'h7F, 8'h80, 8'hC8, 8'hFF};
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(99, 0));
            if (sel < 70)      ch = 8'($urandom_range(126, 32));
            else if (sel < 78) ch = 8'h0A;
            else if (sel < 84) ch = 8'h0D;
            else if (sel < 94) ch = 8'h08;
            else               ch = junk[$urandom_range(10, 0)];
            send_char(ch);
            vectors++;
            if (tif.cursor_col !== COL_W'(cc) || tif.cursor_row !== ROW_W'(cr)) begin
                miscompares++;
                bad++;
                if (bad <= 8)
                    $display("FAIL rand_cursor step %0d char %h: got (%0d,%0d) required (%0d,%0d)",
                             i, ch, tif.cursor_col, tif.cursor_row, cc, cr);
            end
            if (i % 8 == 0) begin
                x = int'($urandom_range(COLS * 8 - 1, 0));
                y = int'($urandom_range(ROWS * 8 - 1, 0));
                exp = model_read(x, y);
                read_cell(x, y, got);
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL rand_read (%0d,%0d): got %h required %h", x, y, got, exp);
                end
            end
        end
    endtask

    task automatic test_oob_cursor();
        int         xs [5];
        int         ys [5];
        logic [7:0] got, exp, stored;
        xs = '{230, 0, 224, 8, 255};
        ys = '{0, 290, 8, 288, 511};
        send_char(8'h0C);
        send_char(8'h4D);
        send_char(8'h4E);
        for (int i = 0; i < 5; i++) begin
            read_cell(xs[i], ys[i], got);
            vectors++;
            if (got !== 8'h20) begin
                miscompares++;
                $display("FAIL oob (%0d,%0d): got %h required 20", xs[i], ys[i], got);
            end
        end
        exp = model_read(223, 287);
        read_cell(223, 287, got);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL inrange_edge: got %h required %h", got, exp);
        end
        send_char(8'h0D);
        stored = scr[0][0];
`ifdef TEXT_CONSOLE_CURSOR_EN
        exp = 8'h5F;
`else
        exp = stored;
`endif
        read_cell(2, 3, got);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL cursor_cell: got %h required %h", got, exp);
        end
        read_cell(8, 0, got);
        vectors++;
        if (got !== 8'h4E) begin
            miscompares++;
            $display("FAIL beside_cursor: got %h required 4e", got);
        end
    endtask

    initial begin
        rst = 1'b1;
        tif.in_valid = 1'b0;
        tif.in_char  = 8'h00;
        tif.sx = 8'd0;
        tif.sy = 9'd0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_sweep("blank");
        test_hi();
        test_back_to_back();
        test_controls();
        test_read_first();
        test_clear();
        test_sweep("after_clear");
        test_reset_mid_clear();
        test_reset_mid_stream();
        test_sweep("after_reset");
        test_random();
        test_sweep("random");
        test_oob_cursor();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/text_console_writer.md
# text_console_writer

Writer end of the on-screen text path. Accepts a stream of ASCII characters over a valid/ready handshake, keeps a cursor, and stores glyph codes in a COLS×ROWS character buffer. The overlay renderer reads that buffer with the same `sx`/`sy` pixel coordinates it feeds to `font`, and gets the ASCII code one clock later. It sits between the game-state logic (producer) and the pixel pipeline (consumer).

## Interface
- `COLS`, 28, text columns (224 px / 8)
- `ROWS`, 36, text rows (288 px / 8)

Clock and reset: one clock; reset is synchronous and active-high.

- `clk`  in  1  pixel/system clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  producer has a character
- `in_char`  in  8  ASCII code
- `in_ready`  out  1  writer can accept this cycle
- `busy`  out  1  clear sequence in progress
- `cursor_col`  out  $clog2(COLS)  current column
- `cursor_row`  out  $clog2(ROWS)  current row
- `sx`  in  8  renderer pixel x
- `sy`  in  9  renderer pixel y
- `ascii_char`  out  8  code at cell (`sx[7:3]`, `sy[8:3]`), registered

## Operation
- States: `CONS_IDLE`, `CONS_CLEAR`.
- `in_ready` = (state == `CONS_IDLE`). A transfer happens when `in_valid && in_ready`.
- Codes handled on transfer (write and cursor update happen in the same cycle):
  - 0x20–0x7E: write the code at the cursor, then `col+1`. If `col == COLS-1`, set col to 0 and advance the row.
  - 0x0A (LF): col to 0, advance the row.
  - 0x0D (CR): col to 0.
  - 0x08 (BS): if `col > 0`, `col-1` and write 0x20 at the new position. If `col == 0`, no-op.
  - 0x0C (FF): go to `CONS_CLEAR` and set the cursor to (0,0).
  - Any other code: consumed and ignored.
- Row advance wraps: when `row == ROWS-1`, the next row is 0. There is no scrolling.
- `CONS_CLEAR`:
  - A counter runs 0..COLS*ROWS-1 and writes 0x20 at each address, one per cycle.
  - On the last address the state returns to `CONS_IDLE`.
  - `busy` = (state == `CONS_CLEAR`).
- Buffer address = `row*COLS + col`. Width is $clog2(COLS*ROWS) bits (10 bits for the defaults).
- Read port:
  - `col_r = sx[7:3]`, `row_r = sy[8:3]`.
  - If `col_r >= COLS` or `row_r >= ROWS`, `ascii_char` = 0x20.
  - Otherwise `ascii_char` = the stored code.
  - The read port stays live during clear and returns the partially cleared contents.

## Timing
- `ascii_char` latency: exactly 1 cycle from `sx`/`sy`.
- A write and a read to the same address in the same cycle return the old data (read-first). The new data is visible on the next read.
- Reset:
  - On the cycle `rst` is high: state goes to `CONS_CLEAR`, the clear counter to 0, and the cursor to (0,0).
  - Output values on the cycle after reset: `in_ready`=0, `busy`=1, `cursor_col`=0, `cursor_row`=0, `ascii_char`=0x20.
  - The clear takes COLS*ROWS cycles after `rst` falls (1008 for the defaults). `in_ready` rises on the following cycle.
- Reset asserted mid-clear or mid-stream restarts the clear from address 0. The input character in that cycle is dropped.
- After an FF transfer, `in_ready` is 0 starting the next cycle, for COLS*ROWS cycles.
- Back-to-back transfers in `CONS_IDLE` are accepted at one per cycle.

## Configuration
- `TEXT_CONSOLE_CURSOR_EN` defined:
  - When state == `CONS_IDLE` and the read cell equals (`cursor_col`, `cursor_row`), `ascii_char` = 0x5F ('_') instead of the stored code.
  - Latency is unchanged.
- Undefined: the stored code is always returned, and no cursor-compare logic is built.

## Structure
- Shared package (alongside `game_mode_t`):
  - `console_state_t` enum {`CONS_IDLE`, `CONS_CLEAR`}.
  - Constants `ASCII_SPACE` 0x20, `ASCII_LF` 0x0A, `ASCII_CR` 0x0D, `ASCII_FF` 0x0C, `ASCII_BS` 0x08, `ASCII_CURSOR` 0x5F.
- Sub-module `char_ram`:
  - Simple dual-port RAM with depth COLS*ROWS and 8-bit width.
  - One synchronous write port and one synchronous read-first read port.
  - Must infer BRAM.
- The top level holds the FSM, cursor, clear counter, address multiply and out-of-range mux.

## Test plan
- Reset then idle:
  - `in_ready` stays 0 for 1008 cycles, then 1.
  - A sweep of `sx`/`sy` over all cells returns 0x20 everywhere.
- Send "HI":
  - Reading `sx`=0, `sy`=0 gives 0x48. Reading `sx`=8, `sy`=0 gives 0x49. Both appear 1 cycle later.
  - Cursor ends at (2,0).
- Send 28 × 'A' then 'B':
  - Row 0 is all 0x41.
  - Cell (0,1) holds 0x42.
  - Cursor ends at (1,1).
- Newline, return, backspace and wrap:
  - Send LF 36 times: cursor wraps to row 0.
  - Send "AB", BS: cell (1,0) = 0x20 and cursor = (1,0).
  - Send BS at col 0: nothing changes.
- Clear and reset restart:
  - Send FF with 'X' on screen: `busy` is high for 1008 cycles and the 'X' cell reads 0x20 afterwards.
  - Assert `rst` at clear cycle 500: `in_ready` stays low for a full 1008 cycles after release.
- Out-of-range and cursor overlay:
  - `sx`=230 or `sy`=290 returns 0x20.
  - With `TEXT_CONSOLE_CURSOR_EN` defined, the cursor cell returns 0x5F while idle.
